// File: rtl/load_store_unit.sv
// Load/store unit: converts a pipeline load/store request into a req/gnt/rvalid
// data-memory transaction with byte-lane steering and load sign/zero extension.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [3:0]  d_size_i,
  input  logic        d_unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        illegal_o,
  output logic        error_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t      r_state, w_state_next;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_inc;
  logic [3:0]  r_size;
  logic        r_unsigned;
  logic [1:0]  r_off;
  logic        r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic        r_rvalid, r_illegal, r_error;

  logic        w_access, w_size_ok, w_align_ok, w_legal, w_timeout;
  logic        w_start, w_bad, w_load_done, w_abort;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_lane, w_load;

  assign w_access  = mem_read_i | mem_write_i;
  assign w_size_ok = (d_size_i == 4'b0001) || (d_size_i == 4'b0011) || (d_size_i == 4'b1111);
  assign w_align_ok = (d_size_i == 4'b0001) ||
                      ((d_size_i == 4'b0011) && !addr_i[0]) ||
                      ((d_size_i == 4'b1111) && (addr_i[1:0] == 2'b00));
  assign w_legal   = (mem_read_i ^ mem_write_i) & w_size_ok & w_align_ok;
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_timeout = (w_cnt_inc == TIMEOUT);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_i;
    case (d_size_i)
      4'b0001: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      4'b0011: begin
        w_be    = 4'b0011 << addr_i[1:0];
        w_wdata = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend per the captured size.
  assign w_lane = dmem_rdata_i >> {r_off, 3'b000};

  always_comb begin
    w_load = w_lane;
    case (r_size)
      4'b0001: w_load = {{24{~r_unsigned & w_lane[7]}}, w_lane[7:0]};
      4'b0011: w_load = {{16{~r_unsigned & w_lane[15]}}, w_lane[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_bad        = 1'b0;
    w_load_done  = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access && w_legal) begin
          w_start      = 1'b1;
          w_state_next = REQ;
        end else if (w_access) begin
          w_bad = 1'b1;
        end
      end
      REQ: begin
        // A grant on the last allowed cycle still wins over the timeout.
        if (dmem_gnt_i) begin
          w_state_next = r_we ? IDLE : WAIT;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      WAIT: begin
        if (dmem_rvalid_i) begin
          w_load_done  = 1'b1;
          w_state_next = IDLE;
        end else if (w_timeout) begin
          w_abort      = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_off      <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
      r_illegal  <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_rvalid  <= w_load_done;
      r_illegal <= w_bad;
      r_error   <= w_abort;
      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (r_state != IDLE) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_start) begin
        r_addr     <= {addr_i[31:2], 2'b00};
        r_be       <= w_be;
        r_wdata    <= w_wdata;
        r_we       <= mem_write_i;
        r_size     <= d_size_i;
        r_unsigned <= d_unsigned_i;
        r_off      <= addr_i[1:0];
      end
      if (w_load_done) begin
        r_rdata <= w_load;
      end
    end
  end

  assign stall_o       = (r_state != IDLE) | (w_access & w_legal);
  assign dmem_req_o    = (r_state == REQ);
  assign dmem_we_o     = r_we;
  assign dmem_addr_o   = r_addr;
  assign dmem_be_o     = r_be;
  assign dmem_wdata_o  = r_wdata;
  assign rdata_o       = r_rdata;
  assign rdata_valid_o = r_rvalid;
  assign illegal_o     = r_illegal;
  assign error_o       = r_error;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: stores, signed/unsigned loads, illegal
// accesses, delayed grant, timeout abort and reset during an outstanding load.
module tb_load_store_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        mem_read_i = 1'b0;
  logic        mem_write_i = 1'b0;
  logic [3:0]  d_size_i = 4'b0000;
  logic        d_unsigned_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        illegal_o;
  logic        error_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i = 1'b0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;

  int n_tests = 0;
  int n_fail  = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .mem_read_i    (mem_read_i),
    .mem_write_i   (mem_write_i),
    .d_size_i      (d_size_i),
    .d_unsigned_i  (d_unsigned_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .illegal_o     (illegal_o),
    .error_o       (error_o),
    .dmem_req_o    (dmem_req_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    d_size_i     = 4'b0000;
    d_unsigned_i = 1'b0;
    addr_i       = '0;
    wdata_i      = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/rdata"},  rdata_o, 32'h0);
    check({tag, "/rvalid"}, 32'(rdata_valid_o), 32'd0);
    check({tag, "/illegal"}, 32'(illegal_o), 32'd0);
    check({tag, "/error"},  32'(error_o), 32'd0);
    check({tag, "/req"},    32'(dmem_req_o), 32'd0);
    check({tag, "/we"},     32'(dmem_we_o), 32'd0);
    check({tag, "/be"},     32'(dmem_be_o), 32'd0);
    check({tag, "/addr"},   dmem_addr_o, 32'h0);
    check({tag, "/wdata"},  dmem_wdata_o, 32'h0);
    check({tag, "/stall"},  32'(stall_o), 32'd0);
  endtask

  // Store: grant arrives on REQ cycle index gnt_delay (0 = first REQ cycle).
  task automatic do_store(input string tag, input logic [3:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input int gnt_delay, input logic [31:0] exp_addr,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    mem_write_i = 1'b1; d_size_i = size; addr_i = addr; wdata_i = wd;
    #1 check({tag, "/stall_idle"}, 32'(stall_o), 32'd1);
    step();
    for (int c = 0; c <= gnt_delay; c++) begin
      check({tag, "/req"},   32'(dmem_req_o), 32'd1);
      check({tag, "/addr"},  dmem_addr_o, exp_addr);
      check({tag, "/be"},    32'(dmem_be_o), 32'(exp_be));
      check({tag, "/wdata"}, dmem_wdata_o, exp_wd);
      check({tag, "/we"},    32'(dmem_we_o), 32'd1);
      check({tag, "/stall"}, 32'(stall_o), 32'd1);
      dmem_gnt_i = (c == gnt_delay);
      step();
    end
    dmem_gnt_i = 1'b0;
    idle_inputs();
    #1;
    check({tag, "/stall_done"}, 32'(stall_o), 32'd0);
    check({tag, "/req_done"},   32'(dmem_req_o), 32'd0);
    check({tag, "/error_done"}, 32'(error_o), 32'd0);
    $display("[TB] store %s addr=0x%08h be=%b wdata=0x%08h", tag, addr, exp_be, exp_wd);
  endtask

  // Load: stray rvalid during REQ must be ignored; real rvalid on first WAIT cycle.
  task automatic do_load(input string tag, input logic [3:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [3:0] exp_be, input logic [31:0] rd,
                         input logic [31:0] exp_rd);
    mem_read_i = 1'b1; d_size_i = size; d_unsigned_i = uns; addr_i = addr;
    #1 check({tag, "/stall_idle"}, 32'(stall_o), 32'd1);
    step();
    check({tag, "/req"},   32'(dmem_req_o), 32'd1);
    check({tag, "/we"},    32'(dmem_we_o), 32'd0);
    check({tag, "/addr"},  dmem_addr_o, exp_addr);
    check({tag, "/be"},    32'(dmem_be_o), 32'(exp_be));
    check({tag, "/stall_req"}, 32'(stall_o), 32'd1);
    dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hDEADBEEF;
    step();
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    idle_inputs();
    #1;
    check({tag, "/req_wait"},    32'(dmem_req_o), 32'd0);
    check({tag, "/stall_wait"},  32'(stall_o), 32'd1);
    check({tag, "/rvalid_wait"}, 32'(rdata_valid_o), 32'd0);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rd;
    step();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    #1;
    check({tag, "/rvalid"},     32'(rdata_valid_o), 32'd1);
    check({tag, "/rdata"},      rdata_o, exp_rd);
    check({tag, "/stall_done"}, 32'(stall_o), 32'd0);
    step();
    check({tag, "/rvalid_end"}, 32'(rdata_valid_o), 32'd0);
    check({tag, "/rdata_hold"}, rdata_o, exp_rd);
    $display("[TB] load %s addr=0x%08h mem=0x%08h rdata=0x%08h", tag, addr, rd, rdata_o);
  endtask

  task automatic do_illegal(input string tag, input logic rd, input logic wr,
                            input logic [3:0] size, input logic [31:0] addr);
    mem_read_i = rd; mem_write_i = wr; d_size_i = size; addr_i = addr;
    #1 check({tag, "/stall"}, 32'(stall_o), 32'd0);
    step();
    check({tag, "/illegal"},   32'(illegal_o), 32'd1);
    check({tag, "/req"},       32'(dmem_req_o), 32'd0);
    check({tag, "/stall_nxt"}, 32'(stall_o), 32'd0);
    idle_inputs();
    step();
    check({tag, "/illegal_end"}, 32'(illegal_o), 32'd0);
    check({tag, "/req_end"},     32'(dmem_req_o), 32'd0);
    $display("[TB] illegal %s rd=%b wr=%b size=%b addr=0x%08h", tag, rd, wr, size, addr);
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst_ni = 1'b1;
    step();
    $display("[TB] reset released");

    do_store("sb_1003", 4'b0001, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB);
    do_store("sh_0002", 4'b0011, 32'h0000_0002, 32'h1234_BEEF, 0, 32'h0000_0000, 4'b1100, 32'hBEEF_BEEF);

    do_load("lh_s_2002", 4'b0011, 1'b0, 32'h0000_2002, 32'h0000_2000, 4'b1100, 32'h8001_1234, 32'hFFFF_8001);
    do_load("lh_u_2002", 4'b0011, 1'b1, 32'h0000_2002, 32'h0000_2000, 4'b1100, 32'h8001_1234, 32'h0000_8001);
    do_load("lb_s_3001", 4'b0001, 1'b0, 32'h0000_3001, 32'h0000_3000, 4'b0010, 32'h0000_F700, 32'hFFFF_FFF7);
    do_load("lw_4000",   4'b1111, 1'b0, 32'h0000_4000, 32'h0000_4000, 4'b1111, 32'h8765_4321, 32'h8765_4321);
    do_load("lb_u_3003", 4'b0001, 1'b1, 32'h0000_3003, 32'h0000_3000, 4'b1000, 32'h9A00_0000, 32'h0000_009A);

    do_illegal("lw_misalign", 1'b1, 1'b0, 4'b1111, 32'h0000_0001);
    do_illegal("sh_misalign", 1'b0, 1'b1, 4'b0011, 32'h0000_0101);
    do_illegal("bad_size",    1'b1, 1'b0, 4'b0111, 32'h0000_0000);
    do_illegal("rd_and_wr",   1'b1, 1'b1, 4'b1111, 32'h0000_0000);

    // Grant withheld for three cycles; arrives on the fourth (last allowed) REQ cycle.
    do_store("sw_gnt_late", 4'b1111, 32'h0000_0050, 32'hCAFE_F00D, 3, 32'h0000_0050, 4'b1111, 32'hCAFE_F00D);

    // No grant ever: four REQ cycles, then abort with an error pulse.
    mem_read_i = 1'b1; d_size_i = 4'b1111; addr_i = 32'h0000_0060;
    step();
    for (int c = 0; c < 4; c++) begin
      check("timeout/req", 32'(dmem_req_o), 32'd1);
      check("timeout/error_early", 32'(error_o), 32'd0);
      if (c == 0) idle_inputs();
      step();
    end
    check("timeout/error",  32'(error_o), 32'd1);
    check("timeout/req_off", 32'(dmem_req_o), 32'd0);
    check("timeout/stall",  32'(stall_o), 32'd0);
    check("timeout/rvalid", 32'(rdata_valid_o), 32'd0);
    check("timeout/rdata_kept", rdata_o, 32'h0000_009A);
    step();
    check("timeout/error_end", 32'(error_o), 32'd0);
    $display("[TB] timeout load addr=0x00000060 aborted");

    // Reset while a load waits for data; the late rvalid must be dropped.
    mem_read_i = 1'b1; d_size_i = 4'b1111; addr_i = 32'h0000_0080;
    step();
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    idle_inputs();
    #1 check("rst_wait/stall_wait", 32'(stall_o), 32'd1);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    check_all_zero("rst_wait");
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h5555_AAAA;
    step();
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    #1;
    check("rst_wait/late_rvalid", 32'(rdata_valid_o), 32'd0);
    check("rst_wait/late_rdata",  rdata_o, 32'h0);
    check("rst_wait/late_stall",  32'(stall_o), 32'd0);
    $display("[TB] reset during WAIT, late rvalid dropped");

    do_load("lh_u_0086", 4'b0011, 1'b1, 32'h0000_0086, 32'h0000_0084, 4'b1100, 32'hABCD_0000, 32'h0000_ABCD);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the max cycles spent in REQ or WAIT before abort (range 1..255).
REQ-002 clk_i  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 rst_ni  input  1  SHALL be the synchronous, active-low reset.
REQ-004 mem_read_i  input  1  load request from decode/EX stage.
REQ-005 mem_write_i  input  1  store request from decode/EX stage.
REQ-006 d_size_i  input  4  lane mask: 4'b0001 byte, 4'b0011 half, 4'b1111 word.
REQ-007 d_unsigned_i  input  1  zero-extend load when 1, sign-extend when 0.
REQ-008 addr_i  input  32  byte address.
REQ-009 wdata_i  input  32  store data, right-justified.
REQ-010 stall_o  output  1  pipeline hold.
REQ-011 rdata_o  output  32  extended load result; rdata_valid_o  output  1  one-cycle load-done pulse.
REQ-012 illegal_o  output  1  one-cycle pulse: misaligned, bad size, or read and write both high; error_o  output  1  one-cycle timeout pulse.
REQ-013 dmem_req_o, dmem_we_o  output  1 each; dmem_addr_o  output  32 (bits [1:0] = 0); dmem_be_o  output  4; dmem_wdata_o  output  32.
REQ-014 dmem_gnt_i, dmem_rvalid_i  input  1 each; dmem_rdata_i  input  32.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT.
REQ-016 Access = mem_read_i | mem_write_i; legal when exactly one is high, d_size_i is an encoding listed in REQ-006, byte has any address, half has addr_i[0]=0, word has addr_i[1:0]=0.
REQ-017 In IDLE with a legal access, the unit SHALL register addr, be, wdata, we, size, unsigned and lane offset, and SHALL enter REQ next cycle.
REQ-018 In IDLE with an illegal access, illegal_o SHALL pulse the next cycle, with no dmem request, no stall, and the state staying IDLE.
REQ-019 dmem_be_o SHALL be 4'b0001<<addr[1:0] (byte), 4'b0011<<addr[1:0] (half), 4'b1111 (word).
REQ-020 dmem_wdata_o SHALL be {4{wdata[7:0]}} (byte), {2{wdata[15:0]}} (half), wdata (word).
REQ-021 dmem_addr_o SHALL be {addr[31:2],2'b00}.
REQ-022 In REQ, dmem_req_o SHALL be 1, with addr/be/we/wdata held stable until the cycle dmem_gnt_i=1.
REQ-023 In REQ on gnt: a store SHALL go to IDLE; a load SHALL go to WAIT. dmem_rvalid_i in REQ SHALL be ignored.
REQ-024 In WAIT on dmem_rvalid_i, the unit SHALL extract the lane selected by the registered offset, extend it per size and unsigned, load rdata_o, pulse rdata_valid_o the next cycle, and go to IDLE.
REQ-025 stall_o SHALL be combinationally 1 in IDLE when a legal access is present, and 1 throughout REQ and WAIT; 0 otherwise.
REQ-026 Store latency with gnt on the first REQ cycle SHALL be 2 cycles of stall; load latency with rvalid on the first WAIT cycle SHALL be 3 cycles of stall.
REQ-027 A cycle counter SHALL clear on entry to REQ and to WAIT and increment each cycle there.
REQ-028 When the counter reaches TIMEOUT_CYCLES, the unit SHALL go to IDLE, pulse error_o, drop dmem_req_o and leave rdata_o unchanged.
REQ-029 Requests presented while in REQ/WAIT SHALL be ignored; the pipeline holds them under stall_o.
REQ-030 rdata_o SHALL hold its last value until the next completed load.

Reset
REQ-031 With rst_ni=0 at a clock edge, the state SHALL become IDLE and all registered outputs and the counter SHALL be 0: rdata_o=0, rdata_valid_o=0, illegal_o=0, error_o=0, dmem_req_o=0, dmem_we_o=0, dmem_be_o=0, dmem_addr_o=0, dmem_wdata_o=0.
REQ-032 A reset asserted in REQ or WAIT SHALL abandon the access without any pulse; a late rvalid after reset SHALL be ignored.

Verification
REQ-033 Store byte addr=0x1003, wdata=0xAB, gnt on 1st REQ cycle -> be=4'b1000, wdata_o=0xABABABAB, addr_o=0x1000, we=1, stall 2 cycles.
REQ-034 Load half signed addr=0x2002, rdata_i=0x8001_1234 -> rdata_o=0xFFFF8001 with one rdata_valid_o pulse; the same access unsigned -> 0x00008001.
REQ-035 Load word addr=0x0001 -> illegal_o pulse, dmem_req_o never 1, stall_o=0.
REQ-036 gnt held low 3 cycles -> req/addr/be stable all 4 REQ cycles; with TIMEOUT_CYCLES=4 and gnt never asserted -> error_o pulse, return to IDLE.
REQ-037 rst_ni=0 during WAIT, then rvalid=1 -> no rdata_valid_o, all outputs 0, next legal load completes normally.
